sram_decoder: RTL and testbench

Row decoder for the 128-row register-file SRAM macro with two read ports and one write port. It turns two 7-bit row addresses plus read/write enables into three one-hot wordline vectors: read port 1, read port 2 and the write port. Outputs are registered, so wordlines are glitch-free and aligned to the array clock. It sits between the SRAM control/address logic and the bitcell array.

---
 rtl/sram_pkg.sv | 16 +
 rtl/sram_decoder_onehot_dec.sv | 33 +++
 rtl/sram_decoder.sv | 76 +++++++
 tb/tb_sram_decoder.sv | 119 +++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_pkg
// Description : Shared geometry and wordline type for the register-file SRAM
//               row decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

    localparam int ADDR_W = 7;
    localparam int ROWS   = 2 ** ADDR_W;

    typedef logic [ROWS-1:0] wordline_t;

endpackage : sram_pkg
`default_nettype wire

// File: rtl/sram_decoder_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module      : onehot_dec
// Description : Combinational ADDR_W -> 2**ADDR_W one-hot decoder with enable;
//               output is all zeros when disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_dec
    import sram_pkg::*;
#(
    parameter int ADDR_W_P = ADDR_W
) (
    input  logic [ADDR_W_P-1:0]      addr,
    input  logic                     en,
    output logic [(2**ADDR_W_P)-1:0] onehot
);

    localparam int c_ROWS = 2 ** ADDR_W_P;

    // The address is only looked at under the enable, so an unknown address
    // on a disabled port never reaches the output.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

    logic [c_ROWS-1:0] w_unused_width_tie;
    assign w_unused_width_tie = onehot;

endmodule : onehot_dec
`default_nettype wire

// File: rtl/sram_decoder.sv
`default_nettype none
// ============================================================================
// Module      : sram_decoder
// Description : Registered row decoder for a 2R1W register-file SRAM; the
//               write port shares address_1 and wins over read port 1.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_decoder
    import sram_pkg::*;
#(
    parameter int ADDR_W_P = ADDR_W,
    parameter int ROWS_P   = ROWS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W_P-1:0] address_1,
    input  logic [ADDR_W_P-1:0] address_2,
    input  logic [1:0]          read_enable,
    input  logic                write_enable,
    output logic [ROWS_P-1:0]   read_wl1,
    output logic [ROWS_P-1:0]   read_wl2,
    output logic [ROWS_P-1:0]   write_wl
);

    logic              w_rd1_en;
    logic              w_rd2_en;
    logic              w_wr_en;
    logic [ROWS_P-1:0] w_rd1_dec;
    logic [ROWS_P-1:0] w_rd2_dec;
    logic [ROWS_P-1:0] w_wr_dec;

    logic [ROWS_P-1:0] r_read_wl1;
    logic [ROWS_P-1:0] r_read_wl2;
    logic [ROWS_P-1:0] r_write_wl;

    // Port 1 and the write port share address_1, so a write suppresses read 1.
    assign w_rd1_en = read_enable[0] & ~write_enable;
    assign w_rd2_en = read_enable[1];
    assign w_wr_en  = write_enable;

    onehot_dec #(.ADDR_W_P(ADDR_W_P)) u_dec_rd1 (
        .addr   (address_1),
        .en     (w_rd1_en),
        .onehot (w_rd1_dec)
    );

    onehot_dec #(.ADDR_W_P(ADDR_W_P)) u_dec_rd2 (
        .addr   (address_2),
        .en     (w_rd2_en),
        .onehot (w_rd2_dec)
    );

    onehot_dec #(.ADDR_W_P(ADDR_W_P)) u_dec_wr (
        .addr   (address_1),
        .en     (w_wr_en),
        .onehot (w_wr_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_read_wl1 <= '0;
            r_read_wl2 <= '0;
            r_write_wl <= '0;
        end else begin
            r_read_wl1 <= w_rd1_dec;
            r_read_wl2 <= w_rd2_dec;
            r_write_wl <= w_wr_dec;
        end
    end

    assign read_wl1 = r_read_wl1;
    assign read_wl2 = r_read_wl2;
    assign write_wl = r_write_wl;

endmodule : sram_decoder
`default_nettype wire

// File: tb/tb_sram_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_decoder
// Description : Self-checking bench for sram_decoder using a behavioural
//               one-hot reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_decoder;

    logic         clk = 1'b0;
    logic         rst;
    logic [6:0]   address_1;
    logic [6:0]   address_2;
    logic [1:0]   read_enable;
    logic         write_enable;
    logic [127:0] read_wl1;
    logic [127:0] read_wl2;
    logic [127:0] write_wl;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    sram_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .address_1    (address_1),
        .address_2    (address_2),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .read_wl1     (read_wl1),
        .read_wl2     (read_wl2),
        .write_wl     (write_wl)
    );

    function automatic logic [127:0] row(input logic en, input int a);
        logic [127:0] one;
        one = 128'd1;
        return en ? (one << a) : 128'd0;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then check the registered result after the edge.
    task automatic step(input logic r, input logic [6:0] a1, input logic [6:0] a2,
                        input logic [1:0] re, input logic we, input string tag);
        logic [127:0] e1, e2, ew;
        @(negedge clk);
        rst          = r;
        address_1    = a1;
        address_2    = a2;
        read_enable  = re;
        write_enable = we;
        e1 = r ? 128'd0 : row(re[0] && !we, int'(a1));
        e2 = r ? 128'd0 : row(re[1], int'(a2));
        ew = r ? 128'd0 : row(we, int'(a1));
        @(posedge clk);
        #1;
        chk({tag, ".wl1"}, read_wl1, e1);
        chk({tag, ".wl2"}, read_wl2, e2);
        chk({tag, ".wwl"}, write_wl, ew);
    endtask

    initial begin
        rst          = 1'b1;
        address_1    = '0;
        address_2    = '0;
        read_enable  = '0;
        write_enable = 1'b0;

        step(1'b1, 7'($urandom), 7'($urandom), 2'b11, 1'b1, "rst0");
        step(1'b1, 7'($urandom), 7'($urandom), 2'($urandom), 1'($urandom), "rst1");
        step(1'b0, 7'h3C, 7'h4F, 2'b00, 1'b0, "release");

        step(1'b0, 7'h3C, 7'h4F, 2'b10, 1'b0, "rd2_only");
        chk("rd2_bit79", read_wl2, 128'd1 << 79);
        step(1'b0, 7'h3C, 7'h4F, 2'b00, 1'b1, "wr_only");
        chk("wr_bit60", write_wl, 128'd1 << 60);
        step(1'b0, 7'h3C, 7'h4F, 2'b00, 1'b0, "idle");
        step(1'b0, 7'h3C, 7'h4F, 2'b01, 1'b0, "rd1_only");
        chk("rd1_bit60", read_wl1, 128'd1 << 60);
        step(1'b0, 7'h3C, 7'h4F, 2'b11, 1'b0, "rd_both");
        step(1'b0, 7'h00, 7'h00, 2'b11, 1'b1, "conflict");
        chk("conflict_rd1_zero", read_wl1, 128'd0);
        step(1'b0, 7'h55, 7'h55, 2'b11, 1'b0, "same_addr");

        step(1'b0, 7'h7F, 7'h00, 2'b00, 1'b1, "wr_top");
        chk("wr_bit127", write_wl, 128'd1 << 127);
        step(1'b1, 7'h7F, 7'h00, 2'b00, 1'b1, "rst_mid");
        step(1'b0, 7'h7F, 7'h12, 2'b10, 1'b1, "resume");

        for (int a = 0; a < 128; a++) begin
            step(1'b0, 7'(a), 7'(127 - a), 2'b10, 1'b1, "sweep_w");
        end
        for (int a = 0; a < 128; a++) begin
            step(1'b0, 7'(a), 7'(a), 2'b11, 1'b0, "sweep_r");
        end

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 19) == 0), 7'($urandom), 7'($urandom),
                 2'($urandom), 1'($urandom), "rand");
        end

        step(1'b0, 7'h11, 7'h22, 2'b00, 1'b0, "final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule : tb_sram_decoder
`default_nettype wire
